// File: rtl/inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher: one inverse round per clock, Nr cycles accept-to-result, valid/ready on both sides.
// Optional macro INV_CIPHER_BACK2BACK_EN lets a new block be accepted on the same edge as the output handshake.
module inv_cipher_iter #(
  parameter int MAX_NR = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              in_data,
  input  logic [1:0]                in_size,
  input  logic [128*(MAX_NR+1)-1:0] in_keys,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              out_data,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                      fsm_q, fsm_d;
  logic [3:0]                ctr_q;
  logic [127:0]              state_q;
  logic [128*(MAX_NR+1)-1:0] key_q;
  logic [127:0]              rk [0:MAX_NR];
  logic [3:0]                nr_in;
  logic [127:0]              rk_nr_in;
  logic [127:0]              isb, round_out, final_out;
  logic                      accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box derived from the field inverse (a^254) after the inverse affine map
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b, sq, r;
    b  = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    sq = b;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
      o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
      o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
      o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  for (genvar j = 0; j <= MAX_NR; j++) begin : g_rk
    assign rk[j] = key_q[128*j +: 128];
  end

  always_comb begin
    nr_in    = 4'd14;
    rk_nr_in = in_keys[128*14 +: 128];
    case (in_size)
      2'b00: begin nr_in = 4'd10; rk_nr_in = in_keys[128*10 +: 128]; end
      2'b01: begin nr_in = 4'd12; rk_nr_in = in_keys[128*12 +: 128]; end
      default: ;
    endcase
  end

  assign isb       = inv_shift_sub(state_q);
  assign round_out = inv_mix(isb ^ rk[ctr_q]);
  assign final_out = isb ^ rk[0];
  assign accept    = in_valid & in_ready;
  assign busy      = (fsm_q != IDLE);

  always_comb begin
    fsm_d    = fsm_q;
    in_ready = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = RUN;
      end
      RUN: if (ctr_q == 4'd0) fsm_d = DONE;
      DONE: begin
`ifdef INV_CIPHER_BACK2BACK_EN
        in_ready = out_ready;
        if (out_ready) fsm_d = in_valid ? RUN : IDLE;
`else
        if (out_ready) fsm_d = IDLE;
`endif
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q     <= 4'd0;
      state_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        state_q <= in_data ^ rk_nr_in;
        ctr_q   <= nr_in - 4'd1;
      end else if (fsm_q == RUN) begin
        if (ctr_q != 4'd0) begin
          state_q <= round_out;
          ctr_q   <= ctr_q - 4'd1;
        end else begin
          out_data  <= final_out;
          out_valid <= 1'b1;
        end
      end
    end
  end

  // Keys are captured only at accept so later bus changes cannot disturb the block in flight
  always_ff @(posedge clk) begin
    if (!rst && accept) key_q <= in_keys;
  end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Scoreboard bench for inv_cipher_iter using FIPS-197 appendix C vectors; round keys are expanded here.
// Build with +define+INV_CIPHER_BACK2BACK_EN to exercise back-to-back acceptance.
module tb_inv_cipher_iter;
  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0]  in_data, out_data;
  logic [1:0]    in_size;
  logic [1919:0] in_keys;

  always #5 clk = ~clk;

  inv_cipher_iter #(.MAX_NR(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_size(in_size), .in_keys(in_keys),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  typedef struct {logic [127:0] data; time t_acc; int nr;} exp_t;
  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 0;
  logic prev_valid = 1'b0;
  int   n_tests = 0, n_fail = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic [1919:0] k128, k192, k256;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] fsbox(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01; sq = a;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl(inv,1) ^ rotl(inv,2) ^ rotl(inv,3) ^ rotl(inv,4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {fsbox(w[31:24]), fsbox(w[23:16]), fsbox(w[15:8]), fsbox(w[7:0])};
  endfunction

  // Key 00 01 02 ...; unused round-key slots are filled with noise
  function automatic logic [1919:0] expand(input int nk);
    logic [31:0]   w [0:59];
    logic [1919:0] bus;
    logic [31:0]   t;
    logic [7:0]    rc;
    int            nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) bus[32*i +: 32] = $urandom;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) bus[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return bus;
  endfunction

  // Monitor: pop on each rising out_valid, re-check data at the handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++; have_cur = 0;
          $display("FAIL unexpected_output: got %h expected no output", out_data);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          check("result", out_data, cur.data);
          check("latency", 128'(($time - 5 - cur.t_acc) / 10), 128'(cur.nr));
        end
      end
      if (out_valid && out_ready && have_cur) check("handshake_data", out_data, cur.data);
    end
    prev_valid = out_valid;
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input logic [127:0] d, input logic [1919:0] k, input logic [1:0] sz,
                      input int nr, input bit push);
    exp_t e;
    bit   ok;
    in_data = d; in_keys = k; in_size = sz; in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    if (push) begin
      e.data = PT; e.t_acc = $time; e.nr = nr;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) ok = 1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic scramble();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_size = 2'($urandom);
    for (int i = 0; i < 60; i++) in_keys[32*i +: 32] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    k128 = expand(4);
    k192 = expand(6);
    k256 = expand(8);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_size = '0; in_keys = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_out_data", out_data, 128'h0);
    @(posedge clk); #1;

    // Vectors 1-3
    send(CT128, k128, 2'b00, 10, 1); wait_idle();
    send(CT192, k192, 2'b01, 12, 1); wait_idle();
    send(CT256, k256, 2'b10, 14, 1); wait_idle();
    send(CT256, k256, 2'b11, 14, 1); wait_idle();

    // Output backpressure
    out_ready = 1'b0;
    send(CT128, k128, 2'b00, 10, 1);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("hold_seen", 128'(seen), 128'(1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_data", out_data, PT);
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
`ifdef INV_CIPHER_BACK2BACK_EN
    send(CT128, k128, 2'b00, 10, 1);
    @(negedge clk);
    check("b2b_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    wait_idle();
`else
    @(posedge clk); #1;
    @(negedge clk);
    check("release_valid", 128'(out_valid), 128'(0));
    check("release_in_ready", 128'(in_ready), 128'(1));
    check("release_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
`endif

    // Reset mid-run
    send(CT256, k256, 2'b10, 14, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("rst_no_output", 128'(seen), 128'(0));
    @(posedge clk); #1;
    send(CT128, k128, 2'b00, 10, 1); wait_idle();

    // Input noise during the run
    send(CT256, k256, 2'b11, 14, 1);
    for (int i = 0; i < 14; i++) begin
      scramble();
      @(posedge clk); #1;
    end
    wait_idle();
    send(CT192, k192, 2'b01, 12, 1);
    for (int i = 0; i < 12; i++) begin
      scramble();
      @(posedge clk); #1;
    end
    wait_idle();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
